uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx byte transmitter between NUM_REQ byte producers, e.g. a status reporter, a cipher output stream and a debug echo. Each requester offers bytes on a valid/ready port. The arbiter picks one requester, captures its byte, issues a single-cycle tx_start with stable tx_data, and tracks the transmitter's busy line until the frame completes. It also runs a watchdog for a transmitter that never reports busy.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; must match the transmitter
BUSY_TIMEOUT, 16, max cycles in WAIT_BUSY before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  NUM_REQ*DATA_W  requester i byte at [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  last byte of a packet (used only with the packet-lock option)
req_ready  out  NUM_REQ  one-hot accept; transfer happens when valid&ready in the same cycle
tx_start  out  1  one-cycle start pulse to the transmitter
tx_data  out  DATA_W  byte to the transmitter; held stable from LAUNCH through WAIT_BUSY
tx_busy  in  1  transmitter busy (high one cycle after tx_start, low when the frame ends)
grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester
arb_busy  out  1  high whenever state != IDLE
err_timeout  out  1  sticky; set on watchdog abort, cleared only by rst

Behaviour:
- Reset: state=IDLE, rr_ptr=0, tx_start=0, tx_data=0, grant_id=0, err_timeout=0, timer=0. req_ready=0 while rst=1.
- Grant select (combinational): scan rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first i with req_valid[i]=1 wins.
- req_ready[g]=1 only when state=IDLE, !rst, !tx_busy and g is the winner. At most one bit is set.
- IDLE: on accept, register tx_data<=req_data[g] and grant_id<=g, then go to LAUNCH. If tx_busy=1 (e.g. a frame left over after reset), there is no grant and the state stays IDLE.
- LAUNCH: tx_start=1 for exactly this cycle. timer<=0. Go to WAIT_BUSY.
- WAIT_BUSY: tx_start=0.
  - If tx_busy=1: go to WAIT_DONE.
  - Else if timer==BUSY_TIMEOUT-1: set err_timeout and go to IDLE. The byte is dropped and rr_ptr still advances.
  - Else timer++.
- WAIT_DONE: when tx_busy=0, go to IDLE and update rr_ptr.
- rr_ptr update: rr_ptr<=grant_id+1, wrapping NUM_REQ-1 to 0.
- Accept-to-tx_start latency: 1 cycle. No back-to-back grant; IDLE always lasts at least 1 cycle between frames.
- req_valid dropping after accept has no effect; the captured byte is still sent.
- A requester that drops valid before it is granted is skipped without penalty.
- Reset asserted in any state returns to IDLE on the next edge. No tx_start is issued during reset.
- Unused/illegal state encodings return to IDLE.

Optional Feature:
UART_TX_ARB_PKT_LOCK_EN
- Defined:
  - After accepting a byte with req_last[g]=0, the next IDLE grant goes only to g. Other requesters are masked until g delivers a byte with req_last=1.
  - rr_ptr advances only after the last byte.
  - A watchdog abort releases the lock.
  - The lock persists while g has valid=0; no other requester is served during that time.
- Undefined: req_last is ignored and rr_ptr rotates after every byte.

Test Plan:
- Single requester: req_valid=4'b0001, req_data[7:0]=8'hA5; transmitter model raises busy 1 cycle after start and holds it 110 cycles -> req_ready[0] for 1 cycle; tx_start 1 cycle later with tx_data=8'hA5; arb_busy low 1 cycle after busy falls; grant_id=0.
- Fairness: all four valid continuously with bytes 8'h10/8'h20/8'h30/8'h40 -> tx_data sequence 10,20,30,40,10,… and grant_id 0,1,2,3,0.
- Skip: valid only on 1 and 3, rr_ptr=2 -> requester 3 is granted first, then 1, then 3.
- Watchdog: transmitter model never raises busy -> err_timeout=1 exactly BUSY_TIMEOUT cycles after WAIT_BUSY entry; return to IDLE; next grant goes to the following requester; err_timeout stays 1 until rst.
- Reset mid-frame: rst pulsed during WAIT_DONE while tx_busy=1 -> all outputs at reset values; no req_ready until tx_busy=0; then normal grant from requester 0.
- Packet lock (macro defined): requester 2 sends 3 bytes with last on the third while requester 0 is also valid -> three consecutive grants to 2, then 0. Without the macro, grants alternate 2,0,2.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one byte transmitter between NUM_REQ producers.
// Captures the winning byte, issues a one-cycle tx_start_o with stable
// tx_data_o, follows tx_busy_i until the frame ends, and aborts with a sticky
// err_timeout_o if the transmitter never reports busy.
//
// Optional build macro: UART_TX_ARB_PKT_LOCK_EN
//   When defined, a requester that delivers a byte with req_last_i=0 keeps the
//   grant until it delivers a byte with req_last_i=1 (or a watchdog abort).
//
// Ports:
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   req_valid_i    per-requester byte valid
//   req_data_i     requester i byte at [i*DATA_W +: DATA_W]
//   req_last_i     last byte of a packet (packet-lock build only)
//   req_ready_o    one-hot accept, transfer on valid & ready
//   tx_start_o     one-cycle start pulse to the transmitter
//   tx_data_o      byte to the transmitter, stable from LAUNCH to frame end
//   tx_busy_i      transmitter busy
//   grant_id_o     index of the last accepted requester
//   arb_busy_o     high whenever the arbiter is not IDLE
//   err_timeout_o  sticky watchdog abort flag, cleared only by rst_i
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic                        tx_start_o,
  output logic [DATA_W-1:0]           tx_data_o,
  input  logic                        tx_busy_i,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o,
  output logic                        arb_busy_o,
  output logic                        err_timeout_o
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int TIMER_W = $clog2(BUSY_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [IDX_W-1:0]     rr_ptr_d;
  logic [IDX_W-1:0]     grant_id_q;
  logic [DATA_W-1:0]    tx_data_q;
  logic                 tx_start_q;
  logic                 arb_busy_q;
  logic                 err_timeout_q;
  logic [TIMER_W-1:0]   timer_q;

  logic [NUM_REQ-1:0]   elig_mask;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_REQ-1:0]   ready_vec;
  logic                 accept;

`ifdef UART_TX_ARB_PKT_LOCK_EN
  logic                 lock_q;

  // While a packet is open only its owner may be granted, even if it is idle.
  always_comb begin
    elig_mask = {NUM_REQ{1'b0}};
    if (lock_q) begin
      elig_mask[grant_id_q] = req_valid_i[grant_id_q];
    end else begin
      elig_mask = req_valid_i;
    end
  end
`else
  logic                 unused_last;
  assign unused_last = ^req_last_i;

  // Without packet lock every valid requester competes.
  always_comb begin
    elig_mask = req_valid_i;
  end
`endif

  // Round-robin scan starting at rr_ptr_q; first eligible requester wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = {IDX_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end else begin
        cand = cand + 0;
      end
      if (!win_found && elig_mask[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end else begin
        win_found = win_found;
      end
    end
  end

  // Ready only in IDLE, out of reset and with an idle transmitter.
  always_comb begin
    ready_vec = {NUM_REQ{1'b0}};
    if ((state_q == IDLE) && !rst_i && !tx_busy_i && win_found) begin
      ready_vec[win_idx] = 1'b1;
    end else begin
      ready_vec = {NUM_REQ{1'b0}};
    end
  end

  assign accept = |(ready_vec & req_valid_i);

  // Next round-robin start: one past the last grant, wrapping at NUM_REQ-1.
  always_comb begin
    if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
      rr_ptr_d = {IDX_W{1'b0}};
    end else begin
      rr_ptr_d = grant_id_q + IDX_W'(1);
    end
  end

  // Arbiter FSM with registered transmitter-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      rr_ptr_q      <= {IDX_W{1'b0}};
      grant_id_q    <= {IDX_W{1'b0}};
      tx_data_q     <= {DATA_W{1'b0}};
      tx_start_q    <= 1'b0;
      arb_busy_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      timer_q       <= {TIMER_W{1'b0}};
`ifdef UART_TX_ARB_PKT_LOCK_EN
      lock_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // tx_start rises with the accept edge so it is high during LAUNCH.
          if (accept) begin
            state_q    <= LAUNCH;
            tx_start_q <= 1'b1;
            tx_data_q  <= req_data_i[win_idx*DATA_W +: DATA_W];
            grant_id_q <= win_idx;
            arb_busy_q <= 1'b1;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            lock_q     <= ~req_last_i[win_idx];
`endif
          end else begin
            tx_start_q <= 1'b0;
            arb_busy_q <= 1'b0;
          end
        end
        LAUNCH: begin
          tx_start_q <= 1'b0;
          timer_q    <= {TIMER_W{1'b0}};
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TIMER_W'(BUSY_TIMEOUT - 1)) begin
            // Abort: byte dropped, pointer still moves on, any lock released.
            err_timeout_q <= 1'b1;
            state_q       <= IDLE;
            arb_busy_q    <= 1'b0;
            rr_ptr_q      <= rr_ptr_d;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            lock_q        <= 1'b0;
`endif
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
`ifdef UART_TX_ARB_PKT_LOCK_EN
            // Inside an open packet the pointer stays put.
            if (!lock_q) begin
              rr_ptr_q <= rr_ptr_d;
            end else begin
              rr_ptr_q <= rr_ptr_q;
            end
`else
            rr_ptr_q   <= rr_ptr_d;
`endif
          end else begin
            state_q <= WAIT_DONE;
          end
        end
        default: begin
          state_q    <= IDLE;
          tx_start_q <= 1'b0;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o   = ready_vec;
  assign tx_start_o    = tx_start_q;
  assign tx_data_o     = tx_data_q;
  assign grant_id_o    = grant_id_q;
  assign arb_busy_o    = arb_busy_q;
  assign err_timeout_o = err_timeout_q;

endmodule
